// File: rtl/dma_axiStream_axi4_pkg_t.sv
// Register map of the AXI-Stream/AXI4 DMA block plus the shared types of the
// command sequencer that programs it.
package dma_axiStream_axi4_pkg_t;

    localparam logic [3:0] REG_MIN_ADDR  = 4'h0;
    localparam logic [3:0] REG_MAX_ADDR  = 4'h1;
    localparam logic [3:0] REG_DMA_START = 4'h2;
    localparam logic [3:0] REG_DMA_LEN   = 4'h3;
    localparam logic [3:0] REG_DMA_DIR   = 4'h4;
    localparam logic [3:0] REG_DMA_MODE  = 4'h5;
    localparam logic [3:0] REG_CTRL      = 4'h6;
    localparam logic [3:0] REG_STATUS    = 4'h7;

    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_STOP  = 2'd2;

    localparam logic [1:0] SEQ_OK      = 2'b00;
    localparam logic [1:0] SEQ_ABORT   = 2'b01;
    localparam logic [1:0] SEQ_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        WR_MIN,
        WR_MAX,
        WR_START,
        WR_LEN,
        WR_DIR,
        WR_MODE,
        WR_CTRL,
        GAP,
        POLL_REQ,
        POLL_CHK,
        ABORT_WR,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [31:0] min;
        logic [31:0] max;
        logic [31:0] start;
        logic [31:0] len;
        logic        dir;
        logic        mode;
    } dma_desc_t;

    // Register each sequencer state talks to; polling and stop both target CTRL.
    function automatic logic [3:0] reg_addr(seq_state_t s);
        reg_addr = 4'h0;
        case (s)
            WR_MIN:   reg_addr = REG_MIN_ADDR;
            WR_MAX:   reg_addr = REG_MAX_ADDR;
            WR_START: reg_addr = REG_DMA_START;
            WR_LEN:   reg_addr = REG_DMA_LEN;
            WR_DIR:   reg_addr = REG_DMA_DIR;
            WR_MODE:  reg_addr = REG_DMA_MODE;
            WR_CTRL, POLL_REQ, POLL_CHK, ABORT_WR: reg_addr = REG_CTRL;
            default:  reg_addr = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/dma_axis_axi4_cmd_seq.sv
// Descriptor-driven register initiator for the DMA block: programs, starts, polls, aborts.
// Optional poll timeout is enabled by defining DMA_CMD_SEQ_TIMEOUT_EN.
module dma_axis_axi4_cmd_seq
    import dma_axiStream_axi4_pkg_t::*;
#(
    parameter int REGS_DW     = 32,
    parameter int REGS_AW     = 4,
    parameter int POLL_GAP    = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               desc_valid_i,
    output logic               desc_ready_o,
    input  logic [REGS_DW-1:0] desc_min_i,
    input  logic [REGS_DW-1:0] desc_max_i,
    input  logic [REGS_DW-1:0] desc_start_i,
    input  logic [REGS_DW-1:0] desc_len_i,
    input  logic               desc_dir_i,
    input  logic               desc_mode_i,
    input  logic               abort_i,
    output logic               regs_we_o,
    output logic [REGS_AW-1:0] regs_addr_o,
    output logic [REGS_DW-1:0] regs_wdata_o,
    input  logic [REGS_DW-1:0] regs_rdata_i,
    input  logic               regs_rdy_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         status_o
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    seq_state_t       state;
    seq_state_t       state_next;
    dma_desc_t        desc;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       status_q;
    logic [1:0]       pend_status;
    logic             accept;
    logic             abort_ok;
    logic             timeout_hit;

    assign accept   = desc_valid_i && (state == IDLE);
    assign abort_ok = abort_i && !(state inside {IDLE, DONE, ABORT_WR});

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    // Abort (or timeout) overrides whatever the current state would do, including a write acceptance.
    always_comb begin
        state_next = state;
        if (abort_ok || timeout_hit) begin
            state_next = ABORT_WR;
        end else begin
            case (state)
                IDLE:     if (desc_valid_i) state_next = WR_MIN;
                WR_MIN:   if (regs_rdy_i)   state_next = WR_MAX;
                WR_MAX:   if (regs_rdy_i)   state_next = WR_START;
                WR_START: if (regs_rdy_i)   state_next = WR_LEN;
                WR_LEN:   if (regs_rdy_i)   state_next = WR_DIR;
                WR_DIR:   if (regs_rdy_i)   state_next = WR_MODE;
                WR_MODE:  if (regs_rdy_i)   state_next = WR_CTRL;
                WR_CTRL:  if (regs_rdy_i)   state_next = GAP;
                GAP:      if (gap_cnt == '0) state_next = POLL_REQ;
                POLL_REQ: state_next = POLL_CHK;
                POLL_CHK: state_next = (regs_rdata_i[1:0] == 2'b00) ? DONE : GAP;
                ABORT_WR: state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        regs_we_o    = 1'b0;
        regs_addr_o  = REGS_AW'(reg_addr(state));
        regs_wdata_o = '0;
        case (state)
            WR_MIN:   begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.min);   end
            WR_MAX:   begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.max);   end
            WR_START: begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.start); end
            WR_LEN:   begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.len);   end
            WR_DIR:   begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.dir);   end
            WR_MODE:  begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(desc.mode);  end
            WR_CTRL:  begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(CTRL_START); end
            ABORT_WR: begin regs_we_o = 1'b1; regs_wdata_o = REGS_DW'(CTRL_STOP);  end
            default:  ;
        endcase
        desc_ready_o = (state == IDLE);
        busy_o       = (state != IDLE);
        done_o       = (state == DONE);
    end

    assign status_o = status_q;

    // Descriptor fields deliberately survive reset; only the sequencing state is cleared.
    always_ff @(posedge aclk) begin
        if (accept) begin
            desc.min   <= 32'(desc_min_i);
            desc.max   <= 32'(desc_max_i);
            desc.start <= 32'(desc_start_i);
            desc.len   <= 32'(desc_len_i);
            desc.dir   <= desc_dir_i;
            desc.mode  <= desc_mode_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            gap_cnt <= '0;
        end else if (state_next == GAP && state != GAP) begin
            gap_cnt <= GAP_W'(POLL_GAP - 1);
        end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // The abort cause is latched on entry to ABORT_WR and published when DONE is entered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            status_q    <= SEQ_OK;
            pend_status <= SEQ_OK;
        end else begin
            if (accept) status_q <= SEQ_OK;
            if (state_next == ABORT_WR && state != ABORT_WR)
                pend_status <= abort_ok ? SEQ_ABORT : SEQ_TIMEOUT;
            if (state_next == DONE)
                status_q <= (state == ABORT_WR) ? pend_status : SEQ_OK;
        end
    end

`ifdef DMA_CMD_SEQ_TIMEOUT_EN
    logic        poll_phase;
    logic [31:0] to_cnt;
    logic        unused_rdata;

    assign poll_phase   = state inside {GAP, POLL_REQ, POLL_CHK};
    assign timeout_hit  = poll_phase && (to_cnt >= 32'(TIMEOUT_CYC));
    assign unused_rdata = ^regs_rdata_i[REGS_DW-1:2];

    always_ff @(posedge aclk) begin
        if (areset)               to_cnt <= '0;
        else if (state == WR_CTRL) to_cnt <= '0;
        else if (poll_phase)       to_cnt <= to_cnt + 32'd1;
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = ^{regs_rdata_i[REGS_DW-1:2], TIMEOUT_CYC[0]};
`endif

endmodule

// File: tb/tb_dma_axis_axi4_cmd_seq.sv
// Randomised self-checking bench for the DMA command sequencer with a register-port responder model.
// Timeout scenario runs only when DMA_CMD_SEQ_TIMEOUT_EN is defined.
module tb_dma_axis_axi4_cmd_seq;
    import dma_axiStream_axi4_pkg_t::*;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int PG  = 8;
    localparam int TO  = 50;

    typedef logic [35:0] wr_t;
    typedef wr_t wr7_t [7];

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          desc_valid_i = 1'b0;
    logic          desc_ready_o;
    logic [DW-1:0] desc_min_i = '0, desc_max_i = '0, desc_start_i = '0, desc_len_i = '0;
    logic          desc_dir_i = 1'b0, desc_mode_i = 1'b0, abort_i = 1'b0;
    logic          regs_we_o;
    logic [AW-1:0] regs_addr_o;
    logic [DW-1:0] regs_wdata_o;
    logic [DW-1:0] regs_rdata_i = '0;
    logic          regs_rdy_i;
    logic          busy_o, done_o;
    logic [1:0]    status_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int       rdy_mode = 0;
    logic     rnd_rdy = 1'b1;
    int       busy_cfg = 0;
    logic [1:0] busy_pat = 2'b01;
    int       busy_left = 0;
    logic     prev_rd = 1'b0;

    wr_t        wr_q[$];
    int         acc_q[$];
    int         done_q[$];
    logic [1:0] dstat_q[$];
    int         ctrl_q[$];
    int         stop_cnt = 0;

    dma_axis_axi4_cmd_seq #(
        .REGS_DW(DW), .REGS_AW(AW), .POLL_GAP(PG), .TIMEOUT_CYC(TO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_min_i(desc_min_i), .desc_max_i(desc_max_i),
        .desc_start_i(desc_start_i), .desc_len_i(desc_len_i),
        .desc_dir_i(desc_dir_i), .desc_mode_i(desc_mode_i),
        .abort_i(abort_i),
        .regs_we_o(regs_we_o), .regs_addr_o(regs_addr_o), .regs_wdata_o(regs_wdata_o),
        .regs_rdata_i(regs_rdata_i), .regs_rdy_i(regs_rdy_i),
        .busy_o(busy_o), .done_o(done_o), .status_o(status_o)
    );

    always #5 aclk = ~aclk;

    assign regs_rdy_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_rdy : 1'b0;

    // Responder: a CTRL start arms busy_cfg busy polls; each fresh CTRL read returns status next cycle.
    always @(posedge aclk) begin
        cyc     <= cyc + 1;
        rnd_rdy <= ($urandom_range(0, 3) != 0);
        prev_rd <= !regs_we_o && (regs_addr_o == REG_CTRL);
        if (regs_we_o && regs_rdy_i && regs_addr_o == REG_CTRL && regs_wdata_o == 32'd1) begin
            busy_left <= busy_cfg;
        end else if (!regs_we_o && regs_addr_o == REG_CTRL && !prev_rd) begin
            regs_rdata_i <= {30'($urandom()), (busy_left > 0) ? busy_pat : 2'b00};
            if (busy_left > 0) busy_left <= busy_left - 1;
        end
    end

    always @(negedge aclk) begin
        if (!areset) begin
            if (regs_we_o && regs_rdy_i) wr_q.push_back({regs_addr_o, regs_wdata_o});
            if (regs_we_o && regs_rdy_i && regs_addr_o == REG_CTRL && regs_wdata_o == 32'd1)
                ctrl_q.push_back(cyc);
            if (regs_we_o && regs_addr_o == REG_CTRL && regs_wdata_o == 32'd2) stop_cnt++;
            if (desc_valid_i && desc_ready_o) acc_q.push_back(cyc);
            if (done_o) begin
                done_q.push_back(cyc);
                dstat_q.push_back(status_o);
            end
        end
    end

    function automatic wr7_t exp_writes(input dma_desc_t d);
        exp_writes[0] = {REG_MIN_ADDR,  d.min};
        exp_writes[1] = {REG_MAX_ADDR,  d.max};
        exp_writes[2] = {REG_DMA_START, d.start};
        exp_writes[3] = {REG_DMA_LEN,   d.len};
        exp_writes[4] = {REG_DMA_DIR,   31'd0, d.dir};
        exp_writes[5] = {REG_DMA_MODE,  31'd0, d.mode};
        exp_writes[6] = {REG_CTRL,      32'd1};
    endfunction

    function automatic dma_desc_t rand_desc();
        rand_desc.min   = $urandom();
        rand_desc.max   = $urandom();
        rand_desc.start = $urandom();
        rand_desc.len   = $urandom();
        rand_desc.dir   = 1'($urandom_range(0, 1));
        rand_desc.mode  = 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_fields(input dma_desc_t d);
        desc_min_i   = d.min;
        desc_max_i   = d.max;
        desc_start_i = d.start;
        desc_len_i   = d.len;
        desc_dir_i   = d.dir;
        desc_mode_i  = d.mode;
    endtask

    task automatic send_desc(input dma_desc_t d, output bit ok);
        int n0;
        n0 = acc_q.size();
        drive_fields(d);
        desc_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge aclk); #1;
            if (acc_q.size() > n0) ok = 1'b1;
        end
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n0;
        n0 = done_q.size();
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge aclk); #1;
            if (done_q.size() > n0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (desc_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", desc_ready_o); end
        checks++;
        if ({regs_we_o, busy_o, done_o, status_o} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_ctl: got we/busy/done/status %b expected 00000", {regs_we_o, busy_o, done_o, status_o});
        end
        checks++;
        if ({regs_addr_o, regs_wdata_o} !== 36'd0) begin
            errors++; $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", regs_addr_o, regs_wdata_o);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        dma_desc_t d;
        wr7_t e;
        bit ok;
        int w0, d0, a0;
        d = '{min: 32'h1000, max: 32'h2000, start: 32'h1800, len: 32'h400, dir: 1'b1, mode: 1'b0};
        e = exp_writes(d);
        busy_cfg = 3; busy_pat = 2'b01; rdy_mode = 0;
        w0 = wr_q.size(); d0 = done_q.size(); a0 = acc_q.size();
        send_desc(d, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL basic_accept: got no accept expected accept"); end
        wait_done(500, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL basic_done: got no done expected done"); end
        repeat (3) @(posedge aclk); #1;
        checks++;
        if (done_q.size() - d0 != 1) begin errors++; $display("[TB] FAIL basic_pulses: got %0d expected 1", done_q.size() - d0); end
        checks++;
        if (wr_q.size() - w0 != 7) begin errors++; $display("[TB] FAIL basic_wrcount: got %0d expected 7", wr_q.size() - w0); end
        if (wr_q.size() >= w0 + 7) begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (wr_q[w0+i] !== e[i]) begin errors++; $display("[TB] FAIL basic_wr%0d: got %h expected %h", i, wr_q[w0+i], e[i]); end
            end
        end
        if (done_q.size() > d0 && acc_q.size() > a0) begin
            checks++;
            if (done_q[d0] - acc_q[a0] != 8 + 4 * (PG + 2)) begin
                errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", done_q[d0] - acc_q[a0], 8 + 4 * (PG + 2));
            end
            checks++;
            if (dstat_q[d0] !== SEQ_OK) begin errors++; $display("[TB] FAIL basic_status: got %b expected 00", dstat_q[d0]); end
        end
        checks++;
        if (desc_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_idle: got ready %b busy %b expected 1 0", desc_ready_o, busy_o);
        end
    endtask

    task automatic test_stall();
        dma_desc_t d;
        wr7_t e;
        bit ok, found;
        int w0, nlen;
        d = '{min: 32'h1000, max: 32'h2000, start: 32'h1800, len: 32'h400, dir: 1'b1, mode: 1'b0};
        e = exp_writes(d);
        busy_cfg = 0; rdy_mode = 0;
        w0 = wr_q.size();
        send_desc(d, ok);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (regs_we_o && regs_addr_o == REG_DMA_LEN) found = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL stall_reach: got no LEN write expected LEN write"); end
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({regs_we_o, regs_addr_o, regs_wdata_o} !== {1'b1, REG_DMA_LEN, d.len}) begin
                errors++; $display("[TB] FAIL stall_hold%0d: got %b %h %h expected 1 %h %h", i, regs_we_o, regs_addr_o, regs_wdata_o, REG_DMA_LEN, d.len);
            end
            @(posedge aclk); #1;
        end
        rdy_mode = 0;
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL stall_done: got no done expected done"); end
        nlen = 0;
        for (int i = w0; i < wr_q.size(); i++) if (wr_q[i][35:32] == REG_DMA_LEN) nlen++;
        checks++;
        if (nlen != 1) begin errors++; $display("[TB] FAIL stall_lencount: got %0d expected 1", nlen); end
        checks++;
        if (wr_q.size() - w0 != 7) begin errors++; $display("[TB] FAIL stall_wrcount: got %0d expected 7", wr_q.size() - w0); end
        else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (wr_q[w0+i] !== e[i]) begin errors++; $display("[TB] FAIL stall_wr%0d: got %h expected %h", i, wr_q[w0+i], e[i]); end
            end
        end
    endtask

    task automatic test_abort();
        dma_desc_t d;
        bit ok, found, prev;
        int d0;
        d0 = done_q.size();
        abort_i = 1'b1;
        repeat (3) @(posedge aclk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_q.size() != d0 || regs_we_o !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_idle: got busy %b we %b dones %0d expected 0 0 0", busy_o, regs_we_o, done_q.size() - d0);
        end
        abort_i = 1'b0;

        busy_cfg = 1000; busy_pat = 2'(1 + $urandom_range(0, 2)); rdy_mode = 0;
        d = rand_desc();
        send_desc(d, ok);
        found = 1'b0; prev = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!regs_we_o && regs_addr_o == REG_CTRL && prev) found = 1'b1;
            else begin
                prev = !regs_we_o && (regs_addr_o == REG_CTRL);
                @(posedge aclk); #1;
            end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL abort_poll_reach: got no poll expected poll"); end
        abort_i = 1'b1;
        @(posedge aclk); #1;
        abort_i = 1'b0;
        checks++;
        if ({regs_we_o, regs_addr_o, regs_wdata_o} !== {1'b1, REG_CTRL, 32'd2}) begin
            errors++; $display("[TB] FAIL abort_stopwr: got %b %h %h expected 1 %h 2", regs_we_o, regs_addr_o, regs_wdata_o, REG_CTRL);
        end
        @(posedge aclk); #1;
        checks++;
        if (done_o !== 1'b1 || status_o !== SEQ_ABORT) begin
            errors++; $display("[TB] FAIL abort_done: got done %b status %b expected 1 01", done_o, status_o);
        end
        @(posedge aclk); #1;
        checks++;
        if (done_o !== 1'b0 || desc_ready_o !== 1'b1 || status_o !== SEQ_ABORT) begin
            errors++; $display("[TB] FAIL abort_after: got done %b ready %b status %b expected 0 1 01", done_o, desc_ready_o, status_o);
        end

        busy_cfg = 0;
        d = rand_desc();
        send_desc(d, ok);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (regs_we_o && regs_addr_o == REG_DMA_START) found = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        abort_i = 1'b1;
        @(posedge aclk); #1;
        abort_i = 1'b0;
        checks++;
        if (!found || {regs_we_o, regs_addr_o, regs_wdata_o} !== {1'b1, REG_CTRL, 32'd2}) begin
            errors++; $display("[TB] FAIL abort_wins: got %b %h %h expected 1 %h 2", regs_we_o, regs_addr_o, regs_wdata_o, REG_CTRL);
        end
        @(posedge aclk); #1;
        checks++;
        if (done_o !== 1'b1 || status_o !== SEQ_ABORT) begin
            errors++; $display("[TB] FAIL abort_wr_done: got done %b status %b expected 1 01", done_o, status_o);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_random();
        dma_desc_t d;
        wr7_t e;
        bit ok;
        int w0, d0;
        for (int n = 0; n < 8; n++) begin
            d = rand_desc();
            busy_cfg = $urandom_range(0, 3);
            busy_pat = 2'(1 + $urandom_range(0, 2));
            if (n == 0) begin
                d.len = 32'd0; busy_cfg = 0;
            end else if (n == 1) begin
                d.min = 32'h100; d.max = 32'h200; d.start = 32'h300; busy_cfg = 0;
            end
            e = exp_writes(d);
            rdy_mode = 1;
            w0 = wr_q.size(); d0 = done_q.size();
            send_desc(d, ok);
            wait_done(500, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done: got no done expected done", n); end
            checks++;
            if (wr_q.size() - w0 != 7) begin errors++; $display("[TB] FAIL rand%0d_wrcount: got %0d expected 7", n, wr_q.size() - w0); end
            else begin
                for (int i = 0; i < 7; i++) begin
                    checks++;
                    if (wr_q[w0+i] !== e[i]) begin errors++; $display("[TB] FAIL rand%0d_wr%0d: got %h expected %h", n, i, wr_q[w0+i], e[i]); end
                end
            end
            if (done_q.size() > d0) begin
                checks++;
                if (dstat_q[d0] !== SEQ_OK) begin errors++; $display("[TB] FAIL rand%0d_status: got %b expected 00", n, dstat_q[d0]); end
            end
        end
        rdy_mode = 0;
        @(posedge aclk); #1;
    endtask

    task automatic test_areset_mid();
        dma_desc_t d;
        wr7_t e;
        bit ok, found;
        int w0, d0;
        busy_cfg = 0; rdy_mode = 0;
        d = rand_desc();
        send_desc(d, ok);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (regs_we_o && regs_addr_o == REG_DMA_DIR) found = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        areset = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (!found || regs_we_o !== 1'b0 || desc_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_mid: got we %b ready %b busy %b expected 0 1 0", regs_we_o, desc_ready_o, busy_o);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        d = rand_desc();
        e = exp_writes(d);
        w0 = wr_q.size(); d0 = done_q.size();
        send_desc(d, ok);
        wait_done(300, ok);
        checks++;
        if (!ok || wr_q.size() - w0 != 7) begin
            errors++; $display("[TB] FAIL areset_resume: got done %b writes %0d expected 1 7", ok, wr_q.size() - w0);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (wr_q[w0+i] !== e[i]) begin errors++; $display("[TB] FAIL areset_wr%0d: got %h expected %h", i, wr_q[w0+i], e[i]); end
            end
            checks++;
            if (dstat_q[d0] !== SEQ_OK) begin errors++; $display("[TB] FAIL areset_status: got %b expected 00", dstat_q[d0]); end
        end
    endtask

    task automatic test_back_to_back();
        dma_desc_t d1, d2;
        wr7_t e1, e2;
        bit ok;
        int w0, d0, a0;
        busy_cfg = 1; busy_pat = 2'b01; rdy_mode = 0;
        d1 = rand_desc(); d2 = rand_desc();
        e1 = exp_writes(d1); e2 = exp_writes(d2);
        w0 = wr_q.size(); d0 = done_q.size(); a0 = acc_q.size();
        drive_fields(d1);
        desc_valid_i = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() <= a0; i++) begin @(posedge aclk); #1; end
        drive_fields(d2);
        for (int i = 0; i < 300 && acc_q.size() <= a0 + 1; i++) begin @(posedge aclk); #1; end
        desc_valid_i = 1'b0;
        for (int i = 0; i < 300 && done_q.size() < d0 + 2; i++) begin @(posedge aclk); #1; end
        checks++;
        if (acc_q.size() - a0 != 2 || done_q.size() - d0 != 2) begin
            errors++; $display("[TB] FAIL b2b_counts: got accepts %0d dones %0d expected 2 2", acc_q.size() - a0, done_q.size() - d0);
        end else begin
            checks++;
            if (acc_q[a0+1] != done_q[d0] + 1) begin
                errors++; $display("[TB] FAIL b2b_gap: got accept at %0d expected %0d", acc_q[a0+1], done_q[d0] + 1);
            end
            checks++;
            if (dstat_q[d0] !== SEQ_OK || dstat_q[d0+1] !== SEQ_OK) begin
                errors++; $display("[TB] FAIL b2b_status: got %b %b expected 00 00", dstat_q[d0], dstat_q[d0+1]);
            end
        end
        checks++;
        if (wr_q.size() - w0 != 14) begin errors++; $display("[TB] FAIL b2b_wrcount: got %0d expected 14", wr_q.size() - w0); end
        else begin
            for (int i = 0; i < 14; i++) begin
                checks++;
                if (wr_q[w0+i] !== ((i < 7) ? e1[i] : e2[i-7])) begin
                    errors++; $display("[TB] FAIL b2b_wr%0d: got %h expected %h", i, wr_q[w0+i], (i < 7) ? e1[i] : e2[i-7]);
                end
            end
        end
    endtask

`ifdef DMA_CMD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        dma_desc_t d;
        bit ok;
        int d0, c0, s0;
        busy_cfg = 100000; busy_pat = 2'b10; rdy_mode = 0;
        d = rand_desc();
        d0 = done_q.size(); c0 = ctrl_q.size(); s0 = stop_cnt;
        send_desc(d, ok);
        wait_done(300, ok);
        checks++;
        if (!ok || ctrl_q.size() <= c0) begin
            errors++; $display("[TB] FAIL timeout_done: got done %b start %0d expected 1 1", ok, ctrl_q.size() - c0);
        end else begin
            checks++;
            if (done_q[d0] - ctrl_q[c0] > TO + PG + 2 || done_q[d0] - ctrl_q[c0] < TO) begin
                errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", done_q[d0] - ctrl_q[c0], TO, TO + PG + 2);
            end
            checks++;
            if (dstat_q[d0] !== SEQ_TIMEOUT) begin errors++; $display("[TB] FAIL timeout_status: got %b expected 10", dstat_q[d0]); end
        end
        checks++;
        if (stop_cnt - s0 != 1) begin errors++; $display("[TB] FAIL timeout_stop: got %0d expected 1", stop_cnt - s0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_random();
        test_areset_mid();
        test_back_to_back();
`ifdef DMA_CMD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
